// File: rtl/axis_weight_packer.sv
// axis_weight_packer
// Packs a narrow AXI-Stream of weight words into wide beats for the weight
// rotator. A config handshake sets the packet length in words. The final,
// possibly partial, beat carries tkeep for the used lanes and tlast.
//
// Ports:
//   aclk, areset         clock and synchronous active-high reset
//   cfg_valid/cfg_ready  packet config handshake; cfg_words = packet length
//   s_axis_*             narrow input stream, one weight word per transfer
//   m_axis_*             wide output stream (tdata/tkeep/tlast)
//   err_len              sticky tlast/count mismatch flag
//
// Optional feature: define AXIS_WEIGHT_PACKER_CHECK_EN to compare the input
// s_axis_tlast against the configured count and raise err_len on a mismatch.
// When the macro is undefined, s_axis_tlast is ignored and err_len is 0.
module axis_weight_packer #(
  parameter int WORD_WIDTH         = 8,
  parameter int S_WEIGHTS_WIDTH_HF = 128,
  parameter int BITS_WORDS         = 20
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [BITS_WORDS-1:0]           cfg_words,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [WORD_WIDTH-1:0]           s_axis_tdata,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [S_WEIGHTS_WIDTH_HF-1:0]   m_axis_tdata,
  output logic [S_WEIGHTS_WIDTH_HF/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            err_len
);

  localparam int LANES  = S_WEIGHTS_WIDTH_HF / WORD_WIDTH;
  localparam int BPW    = WORD_WIDTH / 8;
  localparam int KEEP_W = S_WEIGHTS_WIDTH_HF / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic                          r_cfg_ready;
  logic [BITS_WORDS-1:0]         r_remaining;
  logic [LANE_W-1:0]             r_lane;
  logic [S_WEIGHTS_WIDTH_HF-1:0] r_asm_data;
  logic [KEEP_W-1:0]             r_asm_keep;
  logic                          r_asm_last;
  logic                          r_asm_full;
  logic [S_WEIGHTS_WIDTH_HF-1:0] r_out_data;
  logic [KEEP_W-1:0]             r_out_keep;
  logic                          r_out_last;
  logic                          r_out_valid;

  logic                          w_cfg_fire;
  logic                          w_accept;
  logic                          w_out_free;
  logic                          w_last_word;
  logic                          w_new_complete;
  logic                          w_new_to_out;
  logic [S_WEIGHTS_WIDTH_HF-1:0] w_new_data;
  logic [KEEP_W-1:0]             w_new_keep;

  assign cfg_ready      = r_cfg_ready;
  assign w_cfg_fire     = cfg_valid & r_cfg_ready;
  // Output register can take a beat if empty or emptying this cycle.
  assign w_out_free     = ~r_out_valid | m_axis_tready;
  // A complete beat stuck behind a stalled output register blocks input.
  assign s_axis_tready  = (r_state == ST_PACK) & ~(r_asm_full & ~w_out_free);
  assign w_accept       = s_axis_tvalid & s_axis_tready;
  assign w_last_word    = (r_remaining == BITS_WORDS'(1));
  assign w_new_complete = (r_lane == LANE_W'(LANES - 1)) | w_last_word;
  // A beat completed by this word bypasses the assembly register when it can;
  // a waiting complete beat has priority for the output register.
  assign w_new_to_out   = w_accept & w_new_complete & w_out_free & ~r_asm_full;

  assign m_axis_tvalid  = r_out_valid;
  assign m_axis_tdata   = r_out_data;
  assign m_axis_tkeep   = r_out_keep;
  assign m_axis_tlast   = r_out_last;

  // Assembly beat with the incoming word merged into its lane.
  always_comb begin
    // A full assembly register is always leaving when a word is accepted,
    // so the new word starts from a cleared beat.
    if (r_asm_full) begin
      w_new_data = {S_WEIGHTS_WIDTH_HF{1'b0}};
      w_new_keep = {KEEP_W{1'b0}};
    end else begin
      w_new_data = r_asm_data;
      w_new_keep = r_asm_keep;
    end
    w_new_data[r_lane*WORD_WIDTH +: WORD_WIDTH] = s_axis_tdata;
    w_new_keep[r_lane*BPW +: BPW]               = {BPW{1'b1}};
  end

  // Next-state logic for the packet FSM.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cfg_fire && (cfg_words != {BITS_WORDS{1'b0}})) begin
          w_state_next = ST_PACK;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_PACK: begin
        if (w_accept && w_last_word) begin
          w_state_next = ST_DRAIN;
        end else begin
          w_state_next = ST_PACK;
        end
      end
      ST_DRAIN: begin
        // Done once nothing waits in assembly and the output beat leaves now.
        if (!r_asm_full && (!r_out_valid || m_axis_tready)) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DRAIN;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state register and registered cfg_ready.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state     <= ST_IDLE;
      r_cfg_ready <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cfg_ready <= (w_state_next == ST_IDLE);
    end
  end

  // Word counter, lane pointer, assembly and output beat registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_remaining <= {BITS_WORDS{1'b0}};
      r_lane      <= {LANE_W{1'b0}};
      r_asm_data  <= {S_WEIGHTS_WIDTH_HF{1'b0}};
      r_asm_keep  <= {KEEP_W{1'b0}};
      r_asm_last  <= 1'b0;
      r_asm_full  <= 1'b0;
      r_out_data  <= {S_WEIGHTS_WIDTH_HF{1'b0}};
      r_out_keep  <= {KEEP_W{1'b0}};
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_cfg_fire) begin
        r_remaining <= cfg_words;
        r_lane      <= {LANE_W{1'b0}};
      end else if (w_accept) begin
        r_remaining <= r_remaining - BITS_WORDS'(1);
        r_lane      <= (r_lane == LANE_W'(LANES - 1)) ? {LANE_W{1'b0}} : r_lane + LANE_W'(1);
      end

      if (w_accept && !w_new_to_out) begin
        r_asm_data <= w_new_data;
        r_asm_keep <= w_new_keep;
        r_asm_last <= w_last_word;
        r_asm_full <= w_new_complete;
      end else if (w_new_to_out || (r_asm_full && w_out_free)) begin
        r_asm_data <= {S_WEIGHTS_WIDTH_HF{1'b0}};
        r_asm_keep <= {KEEP_W{1'b0}};
        r_asm_last <= 1'b0;
        r_asm_full <= 1'b0;
      end

      if (r_asm_full && w_out_free) begin
        r_out_data  <= r_asm_data;
        r_out_keep  <= r_asm_keep;
        r_out_last  <= r_asm_last;
        r_out_valid <= 1'b1;
      end else if (w_new_to_out) begin
        r_out_data  <= w_new_data;
        r_out_keep  <= w_new_keep;
        r_out_last  <= w_last_word;
        r_out_valid <= 1'b1;
      end else if (m_axis_tready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef AXIS_WEIGHT_PACKER_CHECK_EN
  logic r_err_len;

  // Sticky flag: producer's tlast disagrees with the configured count.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_err_len <= 1'b0;
    end else if (w_accept && (s_axis_tlast != w_last_word)) begin
      r_err_len <= 1'b1;
    end
  end

  assign err_len = r_err_len;
`else
  logic w_unused_tlast;
  assign w_unused_tlast = s_axis_tlast;
  assign err_len        = 1'b0;
`endif

endmodule

// File: doc/axis_weight_packer.md
# axis_weight_packer

Transmitter-side gearbox for the weight path: accepts a narrow AXI-Stream of single weight words and packs them into S_WEIGHTS_WIDTH_HF-wide beats for the `s_axis_*` port of `axis_weight_rotator`. A config handshake gives the packet length in words. The block drives `tkeep` and `tlast` on the final, possibly partial, beat of that packet, exactly as the rotator expects. It replaces the software/bench word feeder in the integrated design.

## Interface
- `WORD_WIDTH`, 8: bits per weight word; must be a multiple of 8.
- `S_WEIGHTS_WIDTH_HF`, 128: output beat width in bits; must be a multiple of `WORD_WIDTH`.
- `BITS_WORDS`, 20: width of the packet word count.
- Derived: `LANES = S_WEIGHTS_WIDTH_HF/WORD_WIDTH`; `BYTES_PER_WORD = WORD_WIDTH/8`.
- `aclk`  in  1  sole clock; all logic on rising edge.
- `areset`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  packet config offered.
- `cfg_ready`  out  1  high only in IDLE.
- `cfg_words`  in  BITS_WORDS  total weight words in the packet.
- `s_axis_tvalid`  in  1  input word valid.
- `s_axis_tready`  out  1  input word accepted when `tvalid & tready`.
- `s_axis_tdata`  in  WORD_WIDTH  weight word.
- `s_axis_tlast`  in  1  producer's end-of-packet marker; used only under the config macro.
- `m_axis_tvalid`  out  1  output beat valid.
- `m_axis_tready`  in  1  downstream ready; this is the rotator's `s_axis_tready`.
- `m_axis_tdata`  out  S_WEIGHTS_WIDTH_HF  packed beat.
- `m_axis_tkeep`  out  S_WEIGHTS_WIDTH_HF/8  byte enables.
- `m_axis_tlast`  out  1  final beat of the packet.
- `err_len`  out  1  sticky length-mismatch flag.

## Operation
- States:
  - IDLE: `cfg_ready=1`. On `cfg_valid`, latch `cfg_words` into `remaining` and set `lane=0`. Go to PACK, or stay in IDLE if `cfg_words==0`; nothing is emitted for a zero-length packet.
  - PACK: accept words. Word k of a beat goes to lane k, bits `[k*WORD_WIDTH +: WORD_WIDTH]`, so the first word lands in the LSBs.
  - DRAIN: all words have been accepted; wait until the last beat has left the output register, then go to IDLE.
- Two beat registers:
  - Assembly register fills lane by lane.
  - Output register drives `m_axis_*`.
  - A beat is complete when `lane==LANES-1` is written or `remaining` reaches 1. A complete beat moves to the output register on the same edge if the output register is empty or is being consumed that cycle (`m_axis_tready`). Otherwise it waits in the assembly register.
- `s_axis_tready` = (state==PACK) and NOT (assembly register holds a complete beat that cannot move).
- Partial final beat:
  - Unused lanes: data zero, `tkeep` bits zero.
  - Used lanes: all `BYTES_PER_WORD` bits of `tkeep` set.
  - `tlast=1` only on the final beat.
- `remaining` decrements by 1 per accepted word. `lane` wraps from LANES-1 to 0.
- Beat count per packet = ceil(cfg_words/LANES).

## Timing
- Reset values:
  - `cfg_ready=0` in the reset cycle, then 1 in IDLE.
  - `s_axis_tready=0`, `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tkeep=0`, `m_axis_tdata=0`, `err_len=0`.
  - State is IDLE and both beat registers are empty.
- Latency: beat is valid on `m_axis` one cycle after the edge that accepts its last word.
- Throughput:
  - 1 word/cycle sustained with `m_axis_tready` held high; no bubbles between beats.
  - First word can be accepted the cycle after the cfg handshake.
- Handshake rules:
  - `m_axis_tdata`, `m_axis_tkeep` and `m_axis_tlast` stay stable while `tvalid & !tready`.
  - `m_axis_tvalid` never drops without a handshake.
- Backpressure: if the output register is full and stalled and the assembly beat is complete, `s_axis_tready` drops in the same cycle, combinationally from the registered state and `m_axis_tready`.
- Reset mid-packet: all partial and output beats are discarded, with no `tlast` emitted. `err_len` clears.

## Configuration
- `AXIS_WEIGHT_PACKER_CHECK_EN` defined:
  - Compare `s_axis_tlast` with the count.
  - `tlast=1` on a word other than the last counted word, or `tlast=0` on the last counted word, sets `err_len`. It stays set until `areset`.
  - Packing continues purely by count; `m_axis_tlast` is always count-based.
- Undefined: `s_axis_tlast` is ignored and `err_len` is tied to 0.

## Test plan
- `LANES=16`, `cfg_words=48`, words 0..47, `m_axis_tready=1`:
  - 3 beats, `tkeep=16'hFFFF` on all three, `tlast` on beat 3 only.
  - Beat 1 data bits [7:0]=0 and [127:120]=15.
  - Beats back-to-back, no input stall.
- `cfg_words=20`: 2 beats; beat 2 `tkeep=16'h000F`, lanes 4..15 zero, `tlast=1`.
- Same as the 48-word case but `m_axis_tready` low for 40 cycles starting at the first `tvalid`:
  - `s_axis_tready` drops after 32 words accepted.
  - Beat 1 held stable throughout.
  - No word lost or duplicated; order is preserved.
- `cfg_words=0`: `cfg_ready` back high next cycle; `m_axis_tvalid` stays 0.
- `areset` pulse after 10 of 48 words accepted: all outputs at reset values the next cycle. A new 16-word packet then emits exactly 1 beat with `tlast=1`.
- With `AXIS_WEIGHT_PACKER_CHECK_EN`, `cfg_words=20`, `s_axis_tlast` on word 18: `err_len=1` from the next cycle onward. 2 beats are still emitted, with `tlast` on beat 2.
